// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, stalls WAIT_STATES cycles,
// then returns a single-cycle response with read data or an address-error flag.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    reqValid,
   output logic                    reqReady,
   input  logic                    memRead,
   input  logic                    memWrite,
   input  logic [31:0]             addr,
   input  logic [DATA_WIDTH-1:0]   writeData,
   input  logic [DATA_WIDTH/8-1:0] byteEn,
   output logic                    respValid,
   output logic [DATA_WIDTH-1:0]   readData,
   output logic                    addrError
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CNT_W = 4;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {stIdle, stWait, stResp} state_t;

   state_t                  state, nextState;
   logic [CNT_W-1:0]        cnt, nextCnt;
   logic                    reqRead, reqWrite;
   logic [31:0]             reqAddr;
   logic [DATA_WIDTH-1:0]   reqData;
   logic [BYTES-1:0]        reqBe;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    enterResp;
   logic                    effRead, effWrite, effFault;
   logic [31:0]             effAddr;
   logic [DATA_WIDTH-1:0]   effData;
   logic [BYTES-1:0]        effBe;
   logic [ADDR_WIDTH-1:0]   effIdx;

   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      case (state)
         stIdle: begin
            if (reqValid) begin
               if (WAIT_STATES == 0) begin
                  nextState = stResp;
               end else begin
                  nextState = stWait;
                  nextCnt   = CNT_W'(WAIT_STATES);
               end
            end
         end
         stWait: begin
            if (cnt <= 4'd1) nextState = stResp;
            else             nextCnt   = cnt - 4'd1;
         end
         stResp:  nextState = stIdle;
         default: nextState = stIdle;
      endcase
   end

   assign reqReady  = (state == stIdle);
   assign enterResp = (nextState == stResp) && (state != stResp);

   // With zero wait states RESP is entered straight from IDLE, before the request is latched.
   assign effRead  = (state == stIdle) ? memRead   : reqRead;
   assign effWrite = (state == stIdle) ? memWrite  : reqWrite;
   assign effAddr  = (state == stIdle) ? addr      : reqAddr;
   assign effData  = (state == stIdle) ? writeData : reqData;
   assign effBe    = (state == stIdle) ? byteEn    : reqBe;
   assign effIdx   = effAddr[ADDR_WIDTH+1:2];
   assign effFault = (effAddr[1:0] != 2'b00) || (effAddr[31:ADDR_WIDTH+2] != '0) ||
                     (effRead == effWrite);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= stIdle;
         cnt       <= '0;
         reqRead   <= 1'b0;
         reqWrite  <= 1'b0;
         reqAddr   <= '0;
         reqData   <= '0;
         reqBe     <= '0;
         respValid <= 1'b0;
         readData  <= '0;
         addrError <= 1'b0;
      end else begin
         state     <= nextState;
         cnt       <= nextCnt;
         if (state == stIdle && reqValid) begin
            reqRead  <= memRead;
            reqWrite <= memWrite;
            reqAddr  <= addr;
            reqData  <= writeData;
            reqBe    <= byteEn;
         end
         respValid <= enterResp;
         addrError <= enterResp && effFault;
         readData  <= (enterResp && effRead && !effFault) ? mem[effIdx] : '0;
      end
   end

   // RAM contents survive reset; stores commit on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (enterResp && effWrite && !effFault) begin
         for (int i = 0; i < BYTES; i++) begin
            if (effBe[i]) mem[effIdx][8*i +: 8] <= effData[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array memory model.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rstA, rstB;
   logic        reqValidA, reqReadyA, memReadA, memWriteA, respValidA, addrErrorA;
   logic [31:0] addrA, writeDataA, readDataA;
   logic [3:0]  byteEnA;
   logic        reqValidB, reqReadyB, memReadB, memWriteB, respValidB, addrErrorB;
   logic [31:0] addrB, writeDataB, readDataB;
   logic [3:0]  byteEnB;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [256];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(2)) dutA (
      .clk(clk), .rst(rstA), .reqValid(reqValidA), .reqReady(reqReadyA),
      .memRead(memReadA), .memWrite(memWriteA), .addr(addrA), .writeData(writeDataA),
      .byteEn(byteEnA), .respValid(respValidA), .readData(readDataA), .addrError(addrErrorA));

   data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(0)) dutB (
      .clk(clk), .rst(rstB), .reqValid(reqValidB), .reqReady(reqReadyB),
      .memRead(memReadB), .memWrite(memWriteB), .addr(addrB), .writeData(writeDataB),
      .byteEn(byteEnB), .respValid(respValidB), .readData(readDataB), .addrError(addrErrorB));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit isFault(input bit rd, input bit wr, input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd1024) || (rd == wr);
   endfunction

   // One transaction on dutA: checks latency, response fields, and idle-time outputs.
   task automatic doReq(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      int wt, lat;
      logic [31:0] expData;
      bit flt;
      @(negedge clk);
      memReadA = rd; memWriteA = wr; addrA = a; writeDataA = d; byteEnA = be;
      reqValidA = 1'b1;
      wt = 0;
      while (!reqReadyA && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      if (!reqReadyA) begin
         chk("readyTimeout", 32'(reqReadyA), 32'd1);
         reqValidA = 1'b0;
         return;
      end
      @(posedge clk);
      #1 reqValidA = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!respValidA && lat < 20);
      chk("latency", 32'(lat), 32'd3);
      flt = isFault(rd, wr, a);
      expData = (!flt && rd) ? model[a / 4] : 32'd0;
      chk("readData", readDataA, expData);
      chk("addrError", 32'(addrErrorA), 32'(flt));
      if (!flt && wr) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) model[a / 4][8*i +: 8] = d[8*i +: 8];
      end
      @(negedge clk);
      chk("idleResp", {respValidA, addrErrorA, readDataA[29:0]}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, d, bVal;
      bit rd, wr;
      int wt;
      rstA = 1'b1; rstB = 1'b1;
      reqValidA = 0; memReadA = 0; memWriteA = 0; addrA = 0; writeDataA = 0; byteEnA = 0;
      reqValidB = 0; memReadB = 0; memWriteB = 0; addrB = 0; writeDataB = 0; byteEnB = 0;
      repeat (3) @(negedge clk);
      chk("rstReady", 32'(reqReadyA), 32'd1);
      chk("rstResp", 32'(respValidA), 32'd0);
      chk("rstData", readDataA, 32'd0);
      chk("rstErr", 32'(addrErrorA), 32'd0);
      rstA = 1'b0; rstB = 1'b0;

      for (int i = 0; i < 256; i++) doReq(0, 1, 32'(i * 4), $urandom, 4'hF);

      doReq(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      doReq(1, 0, 32'h10, 32'h0, 4'h0);
      chk("t1Word", model[4], 32'hDEADBEEF);
      doReq(0, 1, 32'h10, 32'h000000AA, 4'b0001);
      doReq(1, 0, 32'h10, 32'h0, 4'h0);
      chk("t2Word", model[4], 32'hDEADBEAA);
      doReq(1, 0, 32'h12, 32'h0, 4'h0);
      doReq(1, 0, 32'h400, 32'h0, 4'h0);
      doReq(1, 0, 32'h10, 32'h0, 4'h0);
      doReq(1, 1, 32'h10, 32'h55555555, 4'hF);
      doReq(1, 0, 32'h10, 32'h0, 4'h0);
      doReq(0, 1, 32'h14, 32'hCAFEF00D, 4'b0000);
      doReq(1, 0, 32'h14, 32'h0, 4'h0);

      // Reset mid-WAIT aborts a store.
      @(negedge clk);
      memReadA = 0; memWriteA = 1; addrA = 32'h20; writeDataA = 32'h12345678; byteEnA = 4'hF;
      reqValidA = 1'b1;
      @(posedge clk);
      #1 reqValidA = 1'b0;
      @(negedge clk);
      chk("waitReady", 32'(reqReadyA), 32'd0);
      rstA = 1'b1;
      #1;
      chk("abortReady", 32'(reqReadyA), 32'd1);
      chk("abortResp", 32'(respValidA), 32'd0);
      @(negedge clk);
      rstA = 1'b0;
      wt = 0;
      repeat (6) begin
         @(negedge clk);
         if (respValidA) wt++;
      end
      chk("abortNoResp", 32'(wt), 32'd0);
      doReq(1, 0, 32'h20, 32'h0, 4'h0);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0:       begin rd = 1; wr = 1; end
            1:       begin rd = 0; wr = 0; end
            2, 3, 4: begin rd = 1; wr = 0; end
            default: begin rd = 0; wr = 1; end
         endcase
         a = 32'($urandom_range(0, 255)) * 4;
         if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
         doReq(rd, wr, a, $urandom, 4'($urandom));
      end

      // Zero wait states, back-to-back loads with reqValid held.
      bVal = $urandom;
      @(negedge clk);
      memReadB = 0; memWriteB = 1; addrB = 32'h40; writeDataB = bVal; byteEnB = 4'hF;
      reqValidB = 1'b1;
      @(posedge clk);
      #1 reqValidB = 1'b0;
      @(negedge clk);
      chk("bStoreResp", 32'(respValidB), 32'd1);
      chk("bStoreErr", 32'(addrErrorB), 32'd0);
      @(negedge clk);
      memReadB = 1; memWriteB = 0; addrB = 32'h40; byteEnB = 4'h0;
      reqValidB = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("bReady", 32'(reqReadyB), 32'(i % 2 == 0));
         chk("bResp", 32'(respValidB), 32'(i % 2 == 1));
         chk("bData", readDataB, (i % 2 == 1) ? bVal : 32'd0);
         @(negedge clk);
      end
      reqValidB = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
